popcount_scheduler: RTL and testbench
=====================================

Name: popcount_scheduler

Overview:
- Shares one Popcount datapath between NUM_REQ requesters using a round-robin arbiter.
- Feeds operands into the shared pipeline and tracks in-flight requester IDs through a tag shift register.
- Routes each returned count back to the requester that issued it.
- Provides a drain handshake so upper layers can quiesce the datapath before reconfiguration or power gating.

Parameters:
- DATA_WIDTH, 1024: operand width; must match the Popcount instance.
- NUM_REQ, 4: number of requesters, 2..16.
- PIPE_LATENCY, 4: cycles from the Popcount pop_in sample edge to a valid pop_out.
- RES_WIDTH, 11: returned count width, equal to $clog2(DATA_WIDTH)+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*DATA_WIDTH  operands; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe.
- rsp_count  out  RES_WIDTH  result; low RES_WIDTH bits of pop_out.
- pop_enable  out  1  drives Popcount enable.
- pop_in  out  DATA_WIDTH  drives Popcount pop_in.
- pop_out  in  DATA_WIDTH  from Popcount pop_out.
- drain_req  in  1  level; request quiesce.
- drain_done  out  1  high while in DRAINED state.
- inflight  out  $clog2(PIPE_LATENCY+2)  number of operations in flight.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM enters RUN; RR pointer is 0.
  - Tag pipe valids clear; inflight=0.
  - pop_enable=0, pop_in=0, rsp_valid=0, rsp_count=0, drain_done=0.
  - Operations in flight at reset are discarded. The datapath has no reset, so its output is ignored because the tags are invalid.
- Arbitration (RUN only):
  - req_ready is combinational from req_valid and the RR pointer.
  - At most one grant per cycle, to the first valid requester at or after the pointer (wrap modulo NUM_REQ).
  - After a grant to requester g, the pointer becomes (g+1) mod NUM_REQ. Without a grant, the pointer holds.
  - req_ready is never high for a requester whose req_valid is low.
  - A requester must hold data stable while valid and not ready.
- Issue:
  - On the grant cycle T, pop_in is registered to req_data[g] at edge T+1.
  - The tag stage-0 entry {valid=1, id=g} is written at the same edge.
  - With no grant, tag stage-0 valid=0 and pop_in holds its value.
- Tag pipe:
  - Depth PIPE_LATENCY, shifting every cycle with no stall.
  - When the final stage is valid, rsp_valid[id]=1 and rsp_count=pop_out[RES_WIDTH-1:0], both registered.
- Latency:
  - A grant at cycle T produces a rsp_valid pulse at cycle T+PIPE_LATENCY+1.
  - Throughput is one operation per cycle. Responses cannot be back-pressured; requesters must accept them.
- pop_enable:
  - Registered; high whenever a grant occurred in the previous cycle or any tag stage is valid.
  - Low when the pipeline is empty, for gating.
- inflight:
  - Counts valid tag stages plus any pending rsp.
  - A simultaneous issue and retire leaves the count unchanged.
- FSM:
  - RUN -> DRAIN when drain_req=1. No new grants in DRAIN.
  - DRAIN -> DRAINED when inflight==0 and no rsp is pending.
  - DRAINED -> RUN when drain_req=0. drain_done=1 only in DRAINED.
  - drain_req dropping during DRAIN returns the FSM to RUN.
  - drain_req asserted with an empty pipe enters DRAINED one cycle later.
- Results equal to DATA_WIDTH (all ones) need the full RES_WIDTH (1024 -> 11 bits); no truncation loss.

Decomposition:
- Shared package popcount_pkg holds:
  - the default DATA_WIDTH;
  - a function computing RES_WIDTH;
  - the FSM state typedef (RUN, DRAIN, DRAINED);
  - the tag struct {valid, id}.
- One natural sub-module is rr_arbiter (NUM_REQ, pointer-based, combinational grant plus registered pointer update). The tag pipe and FSM stay in the top module.

Test Plan:
- Single request: req_valid=4'b0001, data = all ones -> req_ready[0] in the same cycle; rsp_valid=4'b0001 with rsp_count=1024 exactly 5 cycles later; pop_enable then drops.
- All 4 requesting continuously, with data[i] = i+1 set bits -> grants 0,1,2,3,0,... in consecutive cycles; responses arrive in the same order with counts 1,2,3,4; no bubbles.
- Pointer fairness: requesters 1 and 3 valid, pointer=2 -> grant 3, then 1, then 3.
- Drain with 3 operations in flight: drain_req=1 -> no grants; inflight goes 3,2,1,0; drain_done rises after the last rsp_valid; releasing drain resumes grants.
- Reset mid-operation: rst_n=0 for 1 cycle with 4 in flight -> no rsp_valid afterwards; inflight=0; pointer=0.
- Zero operand: data=0 -> rsp_count=0 with rsp_valid asserted.

Source files
------------

// File: rtl/popcount_scheduler_pkg.sv
// Shared types and helpers for the popcount scheduler: default operand width,
// result-width helper, the drain FSM state encoding and the in-flight tag.
package popcount_pkg;

  localparam int DEFAULT_DATA_WIDTH = 1024;

  // Wide enough for up to 16 requesters; narrower configurations ignore the top bits.
  localparam int TAG_ID_WIDTH = 4;

  // A count of DATA_WIDTH set bits needs one bit more than log2(DATA_WIDTH).
  function automatic int res_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic [TAG_ID_WIDTH-1:0] id;
  } tag_t;

endpackage

// File: rtl/popcount_scheduler_if.sv
// Requester-facing bus of the popcount scheduler: per-requester operand
// handshake plus the one-hot response strobe and shared result.
interface popcount_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 1024,
  parameter int RES_WIDTH  = 11
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [RES_WIDTH-1:0]          rsp_count;

  // Requester side: offers operands, receives grants and results.
  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_count
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_count
  );
endinterface

// File: rtl/popcount_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first requester at
// or after the pointer, pointer advances past the winner on each grant.
module rr_arbiter #(
  parameter int  NUM_REQ   = 4,
  localparam int PTR_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 grant_valid,
  output logic [PTR_WIDTH-1:0] grant_id
);

  localparam logic [PTR_WIDTH:0]   NUM_REQ_W = (PTR_WIDTH + 1)'(NUM_REQ);
  localparam logic [PTR_WIDTH-1:0] LAST_ID   = PTR_WIDTH'(NUM_REQ - 1);

  logic [PTR_WIDTH-1:0] ptr_reg;
  logic [PTR_WIDTH-1:0] ptr_next;
  logic [PTR_WIDTH:0]   cand_sum;
  logic [PTR_WIDTH-1:0] cand_id;

  // Scan requesters starting at the pointer, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand_sum    = '0;
    cand_id     = '0;
    if (enable) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        cand_sum = {1'b0, ptr_reg} + (PTR_WIDTH + 1)'(off);
        if (cand_sum >= NUM_REQ_W) begin
          cand_sum = cand_sum - NUM_REQ_W;
        end
        cand_id = cand_sum[PTR_WIDTH-1:0];
        if (!grant_valid && req[cand_id]) begin
          grant_valid = 1'b1;
          grant_id    = cand_id;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = grant_valid && (grant_id == PTR_WIDTH'(gi));
  end

  // Next pointer is one past the winner; it holds when nobody is granted.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_valid) begin
      ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/popcount_scheduler.sv
// Shares one external popcount pipeline between NUM_REQ requesters. A tag
// shift register running alongside the datapath remembers who issued each
// operand so the count can be steered back; a drain FSM lets upper layers
// stop issue and wait for the pipeline to empty.
module popcount_scheduler
  import popcount_pkg::*;
#(
  parameter int  DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int  NUM_REQ      = 4,
  parameter int  PIPE_LATENCY = 4,
  parameter int  RES_WIDTH    = res_width(DATA_WIDTH),
  localparam int INF_WIDTH    = $clog2(PIPE_LATENCY + 2),
  localparam int PTR_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  popcount_scheduler_if.slave   bus,
  output logic                  pop_enable,
  output logic [DATA_WIDTH-1:0] pop_in,
  input  logic [DATA_WIDTH-1:0] pop_out,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [INF_WIDTH-1:0]  inflight
);

  logic [NUM_REQ-1:0]      grant;
  logic                    grant_valid;
  logic [PTR_WIDTH-1:0]    grant_id;

  state_t                  state_reg;
  state_t                  state_next;

  tag_t                    tag_reg [PIPE_LATENCY];
  tag_t                    tag_issue;
  tag_t                    tag_final;
  logic [PIPE_LATENCY-1:0] stage_valid;

  logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];
  logic [DATA_WIDTH-1:0]   pop_in_reg;
  logic                    pop_enable_reg;
  logic [NUM_REQ-1:0]      rsp_valid_reg;
  logic [NUM_REQ-1:0]      rsp_valid_next;
  logic [RES_WIDTH-1:0]    rsp_count_reg;
  logic                    rsp_pending;
  logic [INF_WIDTH-1:0]    inflight_reg;
  logic [INF_WIDTH-1:0]    inflight_next;
  logic                    unused_bits;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (state_reg == RUN),
    .req         (bus.req_valid),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_word
    assign req_word[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar gi = 0; gi < PIPE_LATENCY; gi++) begin : g_stage_valid
    assign stage_valid[gi] = tag_reg[gi].valid;
  end

  assign tag_final   = tag_reg[PIPE_LATENCY-1];
  assign rsp_pending = |rsp_valid_reg;

  // Only the low RES_WIDTH bits of the datapath carry the count.
  assign unused_bits = ^{pop_out[DATA_WIDTH-1:RES_WIDTH], tag_final.id};

  // Tag written into stage 0 for the operand issued this cycle.
  always_comb begin
    tag_issue       = '0;
    tag_issue.valid = grant_valid;
    tag_issue.id    = TAG_ID_WIDTH'(grant_id);
  end

  // Tag shift register: advances every cycle, never stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_reg[i] <= '0;
      end
    end else begin
      tag_reg[0] <= tag_issue;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  // Operand register feeding the datapath; holds its value when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_in_reg <= '0;
    end else if (grant_valid) begin
      pop_in_reg <= req_word[grant_id];
    end
  end

  // Keep the datapath clocked while anything is issued or travelling through it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_enable_reg <= 1'b0;
    end else begin
      pop_enable_reg <= grant_valid || (|stage_valid);
    end
  end

  // Steer the retiring count to the requester named in the final tag.
  always_comb begin
    rsp_valid_next = '0;
    if (tag_final.valid) begin
      rsp_valid_next[tag_final.id[PTR_WIDTH-1:0]] = 1'b1;
    end
  end

  // Response registers; the count holds between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_reg <= '0;
      rsp_count_reg <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      if (tag_final.valid) begin
        rsp_count_reg <= pop_out[RES_WIDTH-1:0];
      end
    end
  end

  // Operations enter on a grant and leave when their response strobe ends.
  always_comb begin
    inflight_next = inflight_reg;
    if (grant_valid && !rsp_pending) begin
      inflight_next = inflight_reg + 1'b1;
    end else if (!grant_valid && rsp_pending) begin
      inflight_next = inflight_reg - 1'b1;
    end
  end

  // In-flight counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  // Drain FSM next state: dropping drain_req always returns to RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (drain_req) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!drain_req) begin
          state_next = RUN;
        end else if ((inflight_reg == '0) && !rsp_pending) begin
          state_next = DRAINED;
        end
      end
      DRAINED: begin
        if (!drain_req) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_count = rsp_count_reg;
  assign pop_enable    = pop_enable_reg;
  assign pop_in        = pop_in_reg;
  assign inflight      = inflight_reg;
  assign drain_done    = (state_reg == DRAINED);

endmodule

// File: tb/tb_popcount_scheduler.sv
// Directed bench for popcount_scheduler: a per-cycle vector table covering
// single issue, zero operand, back-to-back round robin and pointer fairness,
// then hand-written drain and mid-flight reset sequences.
module tb_popcount_scheduler;

  localparam int DW = 1024;
  localparam int NR = 4;
  localparam int PL = 4;
  localparam int RW = 11;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pop_enable;
  logic [DW-1:0] pop_in;
  logic [DW-1:0] pop_out;
  logic          drain_req;
  logic          drain_done;
  logic [IW-1:0] inflight;

  int total = 0;
  int bad   = 0;

  popcount_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .RES_WIDTH(RW)) bus ();

  popcount_scheduler #(
    .DATA_WIDTH   (DW),
    .NUM_REQ      (NR),
    .PIPE_LATENCY (PL),
    .RES_WIDTH    (RW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .pop_enable (pop_enable),
    .pop_in     (pop_in),
    .pop_out    (pop_out),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  // Popcount datapath model: the count of an operand loaded into pop_in is
  // presented on pop_out in time to be sampled PL edges after the load.
  logic [RW-1:0] m1 = '0;
  logic [RW-1:0] m2 = '0;
  logic [RW-1:0] m3 = '0;
  always @(posedge clk) begin
    if (pop_enable) begin
      m1 <= RW'($countones(pop_in));
      m2 <= m1;
      m3 <= m2;
    end
  end
  assign pop_out = DW'(m3);

  typedef struct {
    logic [3:0] vld;
    int         n0, n1, n2, n3;
    logic [3:0] rdy;
    logic [3:0] rv;
    int         cnt;
    int         infl;
    logic       en;
  } vec_t;

  vec_t tv [30];

  function automatic vec_t mk(input logic [3:0] vld, input int n0, input int n1,
                              input int n2, input int n3, input logic [3:0] rdy,
                              input logic [3:0] rv, input int cnt, input int infl,
                              input logic en);
    vec_t v;
    v.vld = vld; v.n0 = n0; v.n1 = n1; v.n2 = n2; v.n3 = n3;
    v.rdy = rdy; v.rv = rv; v.cnt = cnt; v.infl = infl; v.en = en;
    return v;
  endfunction

  function automatic logic [DW-1:0] ones(input int n);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, settle, then sample.
  task automatic step(input logic [3:0] vld, input int n0, input int n1, input int n2,
                      input int n3, input logic drn, input logic rstn);
    @(negedge clk);
    bus.req_valid = vld;
    bus.req_data  = {ones(n3), ones(n2), ones(n1), ones(n0)};
    drain_req     = drn;
    rst_n         = rstn;
    #1;
  endtask

  task automatic check_outs(input string nm, input logic [3:0] rdy, input logic [3:0] rv,
                            input int cnt, input int infl, input logic en, input logic done);
    $display("%s: ready=%b rsp_valid=%b rsp_count=%0d inflight=%0d pop_enable=%b drain_done=%b",
             nm, bus.req_ready, bus.rsp_valid, bus.rsp_count, inflight, pop_enable, drain_done);
    chk({nm, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({nm, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
    if (rv != 4'b0000) chk({nm, ".rsp_count"}, 32'(bus.rsp_count), cnt);
    chk({nm, ".inflight"}, 32'(inflight), infl);
    chk({nm, ".pop_enable"}, 32'(pop_enable), 32'(en));
    chk({nm, ".drain_done"}, 32'(drain_done), 32'(done));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic [3:0] d_rv   [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
  int         d_cnt  [7] = '{0, 0, 5, 6, 7, 0, 0};
  int         d_infl [7] = '{3, 3, 3, 2, 1, 0, 0};
  logic       d_en   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       d_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Single all-ones operand, then a zero operand from requester 3 (pointer back to 0).
    tv[0]  = mk(4'b0001, 1024, 0, 0, 0, 4'b0001, 4'b0000, 0,    0, 1'b0);
    tv[1]  = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0000, 0,    1, 1'b1);
    tv[2]  = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0000, 0,    1, 1'b1);
    tv[3]  = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0000, 0,    1, 1'b1);
    tv[4]  = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0000, 0,    1, 1'b1);
    tv[5]  = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0001, 1024, 1, 1'b1);
    tv[6]  = mk(4'b1000, 0, 0, 0, 0,    4'b1000, 4'b0000, 0,    0, 1'b0);
    // All four streaming with 1..4 set bits.
    tv[7]  = mk(4'b1111, 1, 2, 3, 4,    4'b0001, 4'b0000, 0,    1, 1'b1);
    tv[8]  = mk(4'b1111, 1, 2, 3, 4,    4'b0010, 4'b0000, 0,    2, 1'b1);
    tv[9]  = mk(4'b1111, 1, 2, 3, 4,    4'b0100, 4'b0000, 0,    3, 1'b1);
    tv[10] = mk(4'b1111, 1, 2, 3, 4,    4'b1000, 4'b0000, 0,    4, 1'b1);
    tv[11] = mk(4'b1111, 1, 2, 3, 4,    4'b0001, 4'b1000, 0,    5, 1'b1);
    tv[12] = mk(4'b1111, 1, 2, 3, 4,    4'b0010, 4'b0001, 1,    5, 1'b1);
    tv[13] = mk(4'b1111, 1, 2, 3, 4,    4'b0100, 4'b0010, 2,    5, 1'b1);
    tv[14] = mk(4'b1111, 1, 2, 3, 4,    4'b1000, 4'b0100, 3,    5, 1'b1);
    tv[15] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b1000, 4,    5, 1'b1);
    tv[16] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0001, 1,    4, 1'b1);
    tv[17] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0010, 2,    3, 1'b1);
    tv[18] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0100, 3,    2, 1'b1);
    tv[19] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b1000, 4,    1, 1'b1);
    // Fairness: move pointer to 2, then requesters 1 and 3 alternate starting with 3.
    tv[20] = mk(4'b0010, 0, 7, 0, 0,    4'b0010, 4'b0000, 0,    0, 1'b0);
    tv[21] = mk(4'b1010, 0, 7, 0, 9,    4'b1000, 4'b0000, 0,    1, 1'b1);
    tv[22] = mk(4'b1010, 0, 7, 0, 9,    4'b0010, 4'b0000, 0,    2, 1'b1);
    tv[23] = mk(4'b1010, 0, 7, 0, 9,    4'b1000, 4'b0000, 0,    3, 1'b1);
    tv[24] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0000, 0,    4, 1'b1);
    tv[25] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0010, 7,    4, 1'b1);
    tv[26] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b1000, 9,    3, 1'b1);
    tv[27] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0010, 7,    2, 1'b1);
    tv[28] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b1000, 9,    1, 1'b1);
    tv[29] = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 4'b0000, 0,    0, 1'b0);

    rst_n         = 1'b0;
    drain_req     = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);

    // Reset state.
    step(4'b0000, 0, 0, 0, 0, 1'b0, 1'b1);
    check_outs("reset", 4'b0000, 4'b0000, 0, 0, 1'b0, 1'b0);
    chk("reset.pop_in", 32'(pop_in != '0), 32'd0);
    chk("reset.rsp_count", 32'(bus.rsp_count), 32'd0);

    for (int i = 0; i < 30; i++) begin
      step(tv[i].vld, tv[i].n0, tv[i].n1, tv[i].n2, tv[i].n3, 1'b0, 1'b1);
      check_outs($sformatf("row%0d", i), tv[i].rdy, tv[i].rv, tv[i].cnt,
                 tv[i].infl, tv[i].en, 1'b0);
    end

    // Drain with three operations in flight; drain_req raised on the third grant.
    step(4'b0001, 5, 0, 0, 0, 1'b0, 1'b1);
    chk("drain.issue0", 32'(bus.req_ready), 32'(4'b0001));
    step(4'b0010, 5, 6, 0, 0, 1'b0, 1'b1);
    chk("drain.issue1", 32'(bus.req_ready), 32'(4'b0010));
    step(4'b0100, 5, 6, 7, 0, 1'b1, 1'b1);
    chk("drain.issue2", 32'(bus.req_ready), 32'(4'b0100));
    for (int k = 0; k < 7; k++) begin
      step(4'b1111, 5, 6, 7, 8, 1'b1, 1'b1);
      check_outs($sformatf("drain%0d", k), 4'b0000, d_rv[k], d_cnt[k], d_infl[k],
                 d_en[k], d_done[k]);
    end
    step(4'b1111, 5, 6, 7, 8, 1'b0, 1'b1);
    check_outs("undrain", 4'b0000, 4'b0000, 0, 0, 1'b0, 1'b1);
    step(4'b1111, 5, 6, 7, 8, 1'b0, 1'b1);
    check_outs("resume", 4'b1000, 4'b0000, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'b0000, 0, 0, 0, 0, 1'b0, 1'b1);
      check_outs($sformatf("tail%0d", k), 4'b0000, (k == 4) ? 4'b1000 : 4'b0000,
                 8, 1, 1'b1, 1'b0);
    end

    // Reset with four operations in flight and the pointer parked at 2.
    step(4'b0111, 1, 2, 3, 0, 1'b0, 1'b1);
    chk("rst.issue0", 32'(bus.req_ready), 32'(4'b0001));
    step(4'b0111, 1, 2, 3, 0, 1'b0, 1'b1);
    chk("rst.issue1", 32'(bus.req_ready), 32'(4'b0010));
    step(4'b0111, 1, 2, 3, 0, 1'b0, 1'b1);
    chk("rst.issue2", 32'(bus.req_ready), 32'(4'b0100));
    step(4'b0010, 1, 2, 3, 0, 1'b0, 1'b1);
    chk("rst.issue3", 32'(bus.req_ready), 32'(4'b0010));
    step(4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("rst.inflight_before", 32'(inflight), 32'd4);
    for (int k = 0; k < 8; k++) begin
      step(4'b0000, 0, 0, 0, 0, 1'b0, 1'b1);
      check_outs($sformatf("post_rst%0d", k), 4'b0000, 4'b0000, 0, 0, 1'b0, 1'b0);
      if (k == 0) begin
        chk("post_rst.pop_in", 32'(pop_in != '0), 32'd0);
        chk("post_rst.rsp_count", 32'(bus.rsp_count), 32'd0);
      end
    end
    step(4'b1111, 1, 2, 3, 4, 1'b0, 1'b1);
    chk("post_rst.pointer", 32'(bus.req_ready), 32'(4'b0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
